// File: rtl/hwpf_stride_dedup_queue.sv
// Prefetch request queue that drops requests whose cache line is already queued
// or was recently issued to the dcache; responses pass straight through.
package hwpf_stride_dedup_queue_pkg;
    localparam int HPDCACHE_OFFSET_WIDTH = 6;
    localparam int HPDCACHE_NLINE_WIDTH  = 26;

    typedef struct packed {
        logic [31:0] addr;
        logic [2:0]  size;
        logic [3:0]  tid;
        logic        need_rsp;
    } hpdcache_req_t;

    typedef struct packed {
        logic [31:0] rdata;
        logic [3:0]  tid;
        logic        error;
    } hpdcache_rsp_t;
endpackage

module hwpf_stride_dedup_queue
    import hwpf_stride_dedup_queue_pkg::*;
#(
    parameter int FIFO_DEPTH     = 4,
    parameter int HIST_DEPTH     = 8,
    parameter int DROP_CNT_WIDTH = 16
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      enable_i,
    input  logic                      flush_i,
    input  logic                      in_req_valid_i,
    output logic                      in_req_ready_o,
    input  hpdcache_req_t             in_req_i,
    output logic                      in_rsp_valid_o,
    output hpdcache_rsp_t             in_rsp_o,
    output logic                      out_req_valid_o,
    input  logic                      out_req_ready_i,
    output hpdcache_req_t             out_req_o,
    input  logic                      out_rsp_valid_i,
    input  hpdcache_rsp_t             out_rsp_i,
    output logic [DROP_CNT_WIDTH-1:0] drop_cnt_o
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int HW = (HIST_DEPTH > 1) ? $clog2(HIST_DEPTH) : 1;

    typedef logic [HPDCACHE_NLINE_WIDTH-1:0] nline_t;

    hpdcache_req_t             mem [FIFO_DEPTH];
    logic [AW:0]               wr_ptr;
    logic [AW:0]               rd_ptr;
    logic [AW:0]               count;
    logic                      full;
    logic                      empty;
    logic                      accept;
    logic                      deq;
    logic                      fifo_hit;
    logic                      hist_hit;
    logic                      hit;
    nline_t                    in_nline;
    nline_t                    head_nline;
    nline_t                    hist_nline [HIST_DEPTH];
    logic [HIST_DEPTH-1:0]     hist_valid;
    logic [HW-1:0]             repl_ptr;
    logic [DROP_CNT_WIDTH-1:0] drop_cnt;

    assign count      = wr_ptr - rd_ptr;
    assign full       = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign empty      = (wr_ptr == rd_ptr);
    assign accept     = in_req_valid_i && !full;
    assign deq        = !empty && out_req_ready_i;
    assign in_nline   = in_req_i.addr[HPDCACHE_OFFSET_WIDTH +: HPDCACHE_NLINE_WIDTH];
    assign head_nline = out_req_o.addr[HPDCACHE_OFFSET_WIDTH +: HPDCACHE_NLINE_WIDTH];

    // A slot is occupied when its distance from the read pointer is below the occupancy.
    always_comb begin
        fifo_hit = 1'b0;
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            if (({1'b0, AW'(i) - rd_ptr[AW-1:0]} < count) &&
                (mem[i].addr[HPDCACHE_OFFSET_WIDTH +: HPDCACHE_NLINE_WIDTH] == in_nline))
                fifo_hit = 1'b1;
        end
    end

    always_comb begin
        hist_hit = 1'b0;
        for (int i = 0; i < HIST_DEPTH; i++) begin
            if (hist_valid[i] && (hist_nline[i] == in_nline))
                hist_hit = 1'b1;
        end
    end

    assign hit = enable_i && !in_req_i.need_rsp && (fifo_hit || hist_hit);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (accept && !hit)
                wr_ptr <= wr_ptr + 1'b1;
            if (deq)
                rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (accept && !hit)
            mem[wr_ptr[AW-1:0]] <= in_req_i;
    end

    // Flush wins over an insert in the same cycle.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            hist_valid <= '0;
            repl_ptr   <= '0;
        end else if (flush_i) begin
            hist_valid <= '0;
            repl_ptr   <= '0;
        end else if (deq) begin
            hist_valid[repl_ptr] <= 1'b1;
            repl_ptr <= (repl_ptr == HW'(HIST_DEPTH - 1)) ? '0 : repl_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (deq && !flush_i)
            hist_nline[repl_ptr] <= head_nline;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)
            drop_cnt <= '0;
        else if (accept && hit && (drop_cnt != '1))
            drop_cnt <= drop_cnt + 1'b1;
    end

    assign in_req_ready_o  = !full;
    assign out_req_valid_o = !empty;
    assign out_req_o       = mem[rd_ptr[AW-1:0]];
    assign drop_cnt_o      = drop_cnt;
    assign in_rsp_valid_o  = out_rsp_valid_i;
    assign in_rsp_o        = out_rsp_i;
endmodule

// File: tb/tb_hwpf_stride_dedup_queue.sv
// Randomized and directed bench for hwpf_stride_dedup_queue, checked every cycle
// against a queue-based model of the dedup rules.
module tb_hwpf_stride_dedup_queue;
    import hwpf_stride_dedup_queue_pkg::*;

    localparam int FD   = 4;
    localparam int HD   = 8;
    localparam int DW   = 4;
    localparam int DMAX = (1 << DW) - 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          enable;
    logic          flush;
    logic          in_req_valid;
    logic          in_req_ready;
    hpdcache_req_t in_req;
    logic          in_rsp_valid;
    hpdcache_rsp_t in_rsp;
    logic          out_req_valid;
    logic          out_req_ready;
    hpdcache_req_t out_req;
    logic          out_rsp_valid;
    hpdcache_rsp_t out_rsp;
    logic [DW-1:0] drop_cnt;

    hwpf_stride_dedup_queue #(
        .FIFO_DEPTH(FD), .HIST_DEPTH(HD), .DROP_CNT_WIDTH(DW)
    ) dut (
        .clk_i(clk), .rst_i(rst), .enable_i(enable), .flush_i(flush),
        .in_req_valid_i(in_req_valid), .in_req_ready_o(in_req_ready), .in_req_i(in_req),
        .in_rsp_valid_o(in_rsp_valid), .in_rsp_o(in_rsp),
        .out_req_valid_o(out_req_valid), .out_req_ready_i(out_req_ready), .out_req_o(out_req),
        .out_rsp_valid_i(out_rsp_valid), .out_rsp_i(out_rsp), .drop_cnt_o(drop_cnt)
    );

    always #5 clk = ~clk;

    hpdcache_req_t mq[$];
    logic [25:0]   mh[$];
    int            mdrop;
    int            checks = 0;
    int            errors = 0;

    function automatic logic [25:0] nl(input logic [31:0] a);
        return a[31:6];
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic compare_all();
        chk("in_req_ready", 64'(in_req_ready), 64'(mq.size() < FD));
        chk("out_req_valid", 64'(out_req_valid), 64'(mq.size() > 0));
        chk("drop_cnt", 64'(drop_cnt), 64'(mdrop));
        if (mq.size() > 0)
            chk("out_req", 64'(out_req), 64'(mq[0]));
    endtask

    task automatic model_update();
        bit acc;
        bit dq;
        bit h;
        acc = in_req_valid && (mq.size() < FD);
        dq  = (mq.size() > 0) && out_req_ready;
        h   = 1'b0;
        if (acc && enable && !in_req.need_rsp) begin
            foreach (mq[i]) if (nl(mq[i].addr) == nl(in_req.addr)) h = 1'b1;
            foreach (mh[i]) if (mh[i] == nl(in_req.addr)) h = 1'b1;
        end
        if (acc && h && mdrop < DMAX)
            mdrop++;
        if (dq) begin
            mh.push_back(nl(mq[0].addr));
            if (mh.size() > HD) void'(mh.pop_front());
            void'(mq.pop_front());
        end
        if (acc && !h)
            mq.push_back(in_req);
        if (flush)
            mh.delete();
    endtask

    task automatic cycle(input bit v, input logic [31:0] a, input bit nr,
                         input bit rdy, input bit en, input bit fl);
        in_req_valid      = v;
        in_req.addr       = a;
        in_req.size       = 3'($urandom_range(0, 7));
        in_req.tid        = 4'($urandom_range(0, 15));
        in_req.need_rsp   = nr;
        out_req_ready     = rdy;
        enable            = en;
        flush             = fl;
        out_rsp_valid     = 1'($urandom_range(0, 1));
        out_rsp           = 37'({$urandom, $urandom});
        #1;
        chk("rsp_valid_pass", 64'(in_rsp_valid), 64'(out_rsp_valid));
        chk("rsp_pass", 64'(in_rsp), 64'(out_rsp));
        @(posedge clk);
        model_update();
        @(negedge clk);
        compare_all();
    endtask

    task automatic idle(input bit rdy);
        cycle(1'b0, 32'h0, 1'b0, rdy, 1'b1, 1'b0);
    endtask

    task automatic do_reset();
        in_req_valid = 1'b0;
        flush        = 1'b0;
        rst          = 1'b1;
        #1;
        chk("rst_valid", 64'(out_req_valid), 64'd0);
        chk("rst_ready", 64'(in_req_ready), 64'd1);
        chk("rst_drop", 64'(drop_cnt), 64'd0);
        mq.delete();
        mh.delete();
        mdrop = 0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        enable = 1'b1;
        flush = 1'b0;
        in_req_valid = 1'b0;
        in_req = '0;
        out_req_ready = 1'b0;
        out_rsp_valid = 1'b0;
        out_rsp = '0;
        @(negedge clk);
        do_reset();

        // single request latency
        cycle(1'b1, 32'h1000, 1'b0, 1'b1, 1'b1, 1'b0);
        chk("lat_valid", 64'(out_req_valid), 64'd1);
        chk("lat_addr", 64'(out_req.addr), 64'h1000);
        idle(1'b1);

        // same-line drop while queued
        cycle(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b1);
        cycle(1'b1, 32'h1000, 1'b0, 1'b0, 1'b1, 1'b0);
        cycle(1'b1, 32'h1008, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("same_line_drop", 64'(drop_cnt), 64'd1);
        idle(1'b1);
        chk("one_entry_only", 64'(out_req_valid), 64'd0);

        // history wrap evicts the oldest line
        cycle(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b1);
        for (int k = 0; k < 9; k++)
            cycle(1'b1, 32'(k * 64), 1'b0, 1'b1, 1'b1, 1'b0);
        idle(1'b1);
        cycle(1'b1, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("evicted_not_dropped", 64'(drop_cnt), 64'd1);
        cycle(1'b1, 32'h40, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("hist_dropped", 64'(drop_cnt), 64'd2);
        idle(1'b1);

        // fill to full, then drain in order
        for (int k = 0; k < 5; k++) begin
            cycle(1'b1, 32'h5000 + 32'(k * 64), 1'b0, 1'b0, 1'b1, 1'b0);
            if (k == 3) chk("full_ready_low", 64'(in_req_ready), 64'd0);
        end
        chk("full_head", 64'(out_req.addr), 64'h5000);
        idle(1'b1);
        chk("ready_after_deq", 64'(in_req_ready), 64'd1);
        for (int k = 0; k < 3; k++) idle(1'b1);

        // flush, need_rsp and disable all bypass the filter
        cycle(1'b1, 32'h3000, 1'b0, 1'b1, 1'b1, 1'b0);
        idle(1'b1);
        cycle(1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 1'b1);
        cycle(1'b1, 32'h3000, 1'b0, 1'b1, 1'b1, 1'b0);
        idle(1'b1);
        chk("flush_no_drop", 64'(drop_cnt), 64'd2);
        cycle(1'b1, 32'h3000, 1'b1, 1'b1, 1'b1, 1'b0);
        idle(1'b1);
        cycle(1'b1, 32'h3000, 1'b0, 1'b1, 1'b0, 1'b0);
        idle(1'b1);
        chk("need_rsp_disable_no_drop", 64'(drop_cnt), 64'd2);

        // counter saturation
        cycle(1'b1, 32'h7000, 1'b0, 1'b0, 1'b1, 1'b0);
        for (int k = 0; k < 20; k++)
            cycle(1'b1, 32'h7008, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("drop_saturated", 64'(drop_cnt), 64'd15);

        out_rsp_valid = 1'b1;
        out_rsp.rdata = 32'hCAFE;
        out_rsp.tid   = 4'd2;
        out_rsp.error = 1'b0;
        #1;
        chk("rsp_tid_valid", 64'(in_rsp_valid), 64'd1);
        chk("rsp_tid", 64'(in_rsp.tid), 64'd2);

        // reset with a queued request
        @(negedge clk);
        do_reset();

        for (int n = 0; n < 3000; n++) begin
            cycle(1'($urandom_range(0, 3) != 0),
                  32'($urandom_range(0, 11) * 64 + $urandom_range(0, 63)),
                  1'($urandom_range(0, 9) == 0),
                  1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 9) != 0),
                  1'($urandom_range(0, 29) == 0));
            if (n % 400 == 399) begin
                @(negedge clk);
                do_reset();
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
